// File: rtl/sdu_pkg.sv
// Shared constants and state encoding for the serial debug unit command parser.
package sdu_pkg;

   localparam logic [7:0] ASC_CR = 8'h0D;
   localparam logic [7:0] ASC_LF = 8'h0A;
   localparam logic [7:0] ASC_SP = 8'h20;

   localparam int MAX_DIGITS_DEF = 8;

   typedef logic [2:0] parse_st_t;

   localparam parse_st_t IDLE    = 3'd0;
   localparam parse_st_t GAP     = 3'd1;
   localparam parse_st_t ARG     = 3'd2;
   localparam parse_st_t TAIL    = 3'd3;
   localparam parse_st_t DISCARD = 3'd4;
   localparam parse_st_t OUT     = 3'd5;

endpackage

// File: rtl/sdu_hex_decode.sv
// Classifies one received ASCII byte: hex digit value, letter test and upper-case fold.
module sdu_hex_decode (
   input  logic [7:0] d,
   output logic       is_hex,
   output logic [3:0] nibble,
   output logic       is_letter,
   output logic [7:0] upper
);

   logic is_digit;
   logic is_uc;
   logic is_lc;

   assign is_digit  = (d >= 8'h30) && (d <= 8'h39);
   assign is_uc     = (d >= 8'h41) && (d <= 8'h5A);
   assign is_lc     = (d >= 8'h61) && (d <= 8'h7A);
   assign is_letter = is_uc || is_lc;
   assign upper     = is_lc ? (d & 8'hDF) : d;
   assign is_hex    = is_digit || (is_letter && (upper <= 8'h46));
   // 'A'/'a' have bit 6 set and low nibble 1, so adding 9 yields 10..15
   assign nibble    = d[6] ? (d[3:0] + 4'd9) : d[3:0];

endmodule

// File: rtl/sdu_cmd_parser.sv
// Assembles ASCII lines from the UART receiver into command tokens (letter, hex operand, error).
//
//   state   | meaning
//   IDLE    | waiting for a command letter; spaces and blank lines ignored
//   GAP     | letter seen, skipping spaces before an optional operand
//   ARG     | collecting operand hex digits
//   TAIL    | operand done, only trailing spaces allowed
//   DISCARD | line malformed, swallowing bytes until terminator
//   OUT     | token presented on vld_cmd, receiver stalled
import sdu_pkg::*;

module sdu_cmd_parser #(
   parameter int MAX_DIGITS = MAX_DIGITS_DEF
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [7:0]  d_rx,
   input  logic        vld_rx,
   output logic        rdy_rx,
   output logic [7:0]  cmd,
   output logic [31:0] arg,
   output logic        has_arg,
   output logic        err,
   output logic        vld_cmd,
   input  logic        rdy_cmd
);

   localparam int            CW      = $clog2(MAX_DIGITS + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);

   parse_st_t     state;
   logic [CW-1:0] cnt;

   logic       is_hex;
   logic [3:0] nibble;
   logic       is_letter;
   logic [7:0] upper;
   logic       is_sp;
   logic       is_term;
   logic       acc;

   sdu_hex_decode u_hex_decode (
      .d         (d_rx),
      .is_hex    (is_hex),
      .nibble    (nibble),
      .is_letter (is_letter),
      .upper     (upper)
   );

   assign is_sp   = (d_rx == ASC_SP);
   assign is_term = (d_rx == ASC_CR) || (d_rx == ASC_LF);
   assign rdy_rx  = (state != OUT);
   assign vld_cmd = (state == OUT);
   assign acc     = vld_rx && rdy_rx;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         cnt     <= '0;
         cmd     <= 8'h00;
         arg     <= 32'h0;
         has_arg <= 1'b0;
         err     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (acc && !is_sp && !is_term) begin
               if (is_letter) begin
                  cmd     <= upper;
                  arg     <= 32'h0;
                  has_arg <= 1'b0;
                  cnt     <= '0;
                  state   <= GAP;
               end else begin
                  // no letter yet, so the error token carries a null command
                  cmd     <= 8'h00;
                  arg     <= 32'h0;
                  has_arg <= 1'b0;
                  err     <= 1'b1;
                  state   <= DISCARD;
               end
            end
            GAP: if (acc && !is_sp) begin
               if (is_hex) begin
                  arg     <= {arg[27:0], nibble};
                  has_arg <= 1'b1;
                  cnt     <= CW'(1);
                  state   <= ARG;
               end else if (is_term) begin
                  state   <= OUT;
               end else begin
                  arg     <= 32'h0;
                  has_arg <= 1'b0;
                  err     <= 1'b1;
                  state   <= DISCARD;
               end
            end
            ARG: if (acc) begin
               if (is_hex && (cnt != CNT_MAX)) begin
                  arg   <= {arg[27:0], nibble};
                  cnt   <= cnt + 1'b1;
               end else if (is_sp) begin
                  state <= TAIL;
               end else if (is_term) begin
                  state <= OUT;
               end else begin
                  arg     <= 32'h0;
                  has_arg <= 1'b0;
                  err     <= 1'b1;
                  state   <= DISCARD;
               end
            end
            TAIL: if (acc && !is_sp) begin
               if (is_term) begin
                  state   <= OUT;
               end else begin
                  arg     <= 32'h0;
                  has_arg <= 1'b0;
                  err     <= 1'b1;
                  state   <= DISCARD;
               end
            end
            DISCARD: if (acc && is_term) begin
               state <= OUT;
            end
            OUT: if (rdy_cmd) begin
               err   <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdu_cmd_parser.sv
// Self-checking bench for sdu_cmd_parser: vector table of lines with a token scoreboard.
module tb_sdu_cmd_parser;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [7:0]  d_rx = 8'h00;
   logic        vld_rx = 1'b0;
   logic        rdy_rx;
   logic [7:0]  cmd;
   logic [31:0] arg;
   logic        has_arg;
   logic        err;
   logic        vld_cmd;
   logic        rdy_cmd = 1'b0;

   typedef struct packed {
      logic [7:0]  cmd;
      logic [31:0] arg;
      logic        has_arg;
      logic        err;
   } tok_t;

   typedef struct {
      string line;
      tok_t  tok;
   } vec_t;

   tok_t exp_q[$];
   vec_t vecs[12];
   int   errors = 0;
   int   checks = 0;

   sdu_cmd_parser dut (
      .clk     (clk),
      .rstn    (rstn),
      .d_rx    (d_rx),
      .vld_rx  (vld_rx),
      .rdy_rx  (rdy_rx),
      .cmd     (cmd),
      .arg     (arg),
      .has_arg (has_arg),
      .err     (err),
      .vld_cmd (vld_cmd),
      .rdy_cmd (rdy_cmd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         bit ok;
         int n;
         ok     = 1'b0;
         n      = 0;
         d_rx   = s[i];
         vld_rx = 1'b1;
         while (!ok && n < 200) begin
            @(negedge clk);
            ok = rdy_rx;
            @(posedge clk);
            #1;
            n++;
         end
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL send_timeout: byte %h not accepted after %0d cycles", s[i], n);
         end
      end
      vld_rx = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d tokens outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      vecs[0]  = '{"d 1A2b\r",        '{8'h44, 32'h0000_1A2B, 1'b1, 1'b0}};
      vecs[1]  = '{"R\r\n\r\n",       '{8'h52, 32'h0,         1'b0, 1'b0}};
      vecs[2]  = '{"M 123456789\r",   '{8'h4D, 32'h0,         1'b0, 1'b1}};
      vecs[3]  = '{"G\r",             '{8'h47, 32'h0,         1'b0, 1'b0}};
      vecs[4]  = '{"P 10 x\r",        '{8'h50, 32'h0,         1'b0, 1'b1}};
      vecs[5]  = '{"#5\r",            '{8'h00, 32'h0,         1'b0, 1'b1}};
      vecs[6]  = '{"D1000\n",         '{8'h44, 32'h0000_1000, 1'b1, 1'b0}};
      vecs[7]  = '{"f FFFFFFFF\r",    '{8'h46, 32'hFFFF_FFFF, 1'b1, 1'b0}};
      vecs[8]  = '{"  z  7   \r",     '{8'h5A, 32'h0000_0007, 1'b1, 1'b0}};
      vecs[9]  = '{"e 00000001\r\n",  '{8'h45, 32'h0000_0001, 1'b1, 1'b0}};
      vecs[10] = '{"DG\r",            '{8'h44, 32'h0,         1'b0, 1'b1}};
      vecs[11] = '{"x 5 6\r",         '{8'h58, 32'h0,         1'b0, 1'b1}};

      // token monitor: a handshake seen at negedge completes on the next rising edge
      fork
         forever begin
            tok_t e;
            @(negedge clk);
            if (vld_cmd && rdy_cmd) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_token: got cmd %h arg %h, expected none", cmd, arg);
               end else begin
                  e = exp_q.pop_front();
                  chk("tok_cmd",     {24'h0, cmd},     {24'h0, e.cmd});
                  chk("tok_arg",     arg,              e.arg);
                  chk("tok_has_arg", {31'h0, has_arg}, {31'h0, e.has_arg});
                  chk("tok_err",     {31'h0, err},     {31'h0, e.err});
               end
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #1;
      chk("rst_vld_cmd", {31'h0, vld_cmd}, 32'h0);
      chk("rst_cmd",     {24'h0, cmd},     32'h0);
      chk("rst_arg",     arg,              32'h0);
      chk("rst_has_arg", {31'h0, has_arg}, 32'h0);
      chk("rst_err",     {31'h0, err},     32'h0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_rdy_rx", {31'h0, rdy_rx}, 32'h1);

      rdy_cmd = 1'b1;
      for (int i = 0; i < 12; i++) begin
         exp_q.push_back(vecs[i].tok);
         send_str(vecs[i].line);
      end
      drain();

      // backpressure: token S/5 held 20 cycles while "T\n" waits in the receiver
      rdy_cmd = 1'b0;
      exp_q.push_back('{8'h53, 32'h5, 1'b1, 1'b0});
      exp_q.push_back('{8'h54, 32'h0, 1'b0, 1'b0});
      send_str("S 5\n");
      fork
         send_str("T\n");
      join_none
      repeat (20) begin
         @(negedge clk);
         chk("bp_rdy_rx",  {31'h0, rdy_rx},  32'h0);
         chk("bp_vld_cmd", {31'h0, vld_cmd}, 32'h1);
         chk("bp_cmd",     {24'h0, cmd},     32'h53);
         chk("bp_arg",     arg,              32'h5);
      end
      @(posedge clk);
      #1;
      rdy_cmd = 1'b1;
      drain();
      repeat (4) @(posedge clk);
      #1;

      // reset in the middle of a line
      send_str("W FF");
      chk("pre_rst_cmd", {24'h0, cmd}, 32'h57);
      #3;
      rstn = 1'b0;
      #1;
      chk("midline_vld_cmd", {31'h0, vld_cmd}, 32'h0);
      chk("midline_cmd",     {24'h0, cmd},     32'h0);
      chk("midline_arg",     arg,              32'h0);
      chk("midline_has_arg", {31'h0, has_arg}, 32'h0);
      chk("midline_err",     {31'h0, err},     32'h0);
      chk("midline_rdy_rx",  {31'h0, rdy_rx},  32'h1);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back('{8'h51, 32'h0, 1'b0, 1'b0});
      send_str("Q\r");
      drain();

      // reset while a token is presented
      rdy_cmd = 1'b0;
      send_str("W FFFF\r");
      @(negedge clk);
      chk("out_vld_cmd", {31'h0, vld_cmd}, 32'h1);
      #2;
      rstn = 1'b0;
      #1;
      chk("midout_vld_cmd", {31'h0, vld_cmd}, 32'h0);
      chk("midout_arg",     arg,              32'h0);
      chk("midout_cmd",     {24'h0, cmd},     32'h0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      rdy_cmd = 1'b1;
      exp_q.push_back('{8'h51, 32'h0, 1'b0, 1'b0});
      send_str("Q\r");
      drain();

      repeat (5) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
